act_pipe_unit: RTL and testbench

//   Pipelined, run-time configurable activation stage between the tile accumulator and the output path.

---
 rtl/act_pipe_unit.sv | 195 +++++++++++++++++++
 tb/tb_act_pipe_unit.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_pipe_unit.sv
// rtl/act_pipe_unit.sv - pipelined per-lane FP32 activation stage (bypass/relu/leaky/clamp)
// Ports: clk, rstn (async active-low); cfg_we_i/cfg_mode_i/cfg_alpha_i/cfg_clip_i/cfg_rdy_o
// config write; data_i/last_i/valid_i/ready_o input stream; data_o/last_o/valid_o/ready_i
// output stream; beat_cnt_o beats emitted in the current frame.
module act_pipe_unit #(
    parameter int DW    = 32,
    parameter int LANES = 4,
    parameter int LAT   = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      cfg_we_i,
    input  logic [1:0]                cfg_mode_i,
    input  logic [DW-1:0]             cfg_alpha_i,
    input  logic [DW-1:0]             cfg_clip_i,
    output logic                      cfg_rdy_o,
    input  logic [LANES-1:0][DW-1:0]  data_i,
    input  logic                      last_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    output logic [LANES-1:0][DW-1:0]  data_o,
    output logic                      last_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic [15:0]               beat_cnt_o
);

    localparam logic [1:0] MODE_BYPASS = 2'd0;
    localparam logic [1:0] MODE_RELU   = 2'd1;
    localparam logic [1:0] MODE_LEAKY  = 2'd2;
    localparam logic [1:0] MODE_CLAMP  = 2'd3;

    generate
        if (LAT < 1 || LAT > 4) begin : g_bad_lat
            $fatal(1, "act_pipe_unit: LAT must be in 1..4");
        end
        if (DW != 32) begin : g_bad_dw
            $fatal(1, "act_pipe_unit: DW must be 32");
        end
    endgenerate

    // FP32 multiply, round-to-nearest-even, with subnormal inputs and outputs.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s, found, g, st, rnd;
        logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
        logic [7:0]  ea, eb;
        logic [23:0] ma, mb, mant;
        logic [47:0] p, pn;
        logic [71:0] ext;
        logic [30:0] mag;
        int          lz, be, sh;
        s      = a[31] ^ b[31];
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
        a_zero = (a[30:0] == 31'h0);
        b_zero = (b[30:0] == 31'h0);
        if (a_nan)
            return a | 32'h0040_0000;
        if (b_nan)
            return b | 32'h0040_0000;
        if ((a_inf && b_zero) || (b_inf && a_zero))
            return 32'h7FC0_0000;
        if (a_inf || b_inf)
            return {s, 8'hFF, 23'h0};
        if (a_zero || b_zero)
            return {s, 31'h0};
        // Subnormals use exponent 1 with a clear hidden bit.
        ea = (a[30:23] == 8'h0) ? 8'd1 : a[30:23];
        eb = (b[30:23] == 8'h0) ? 8'd1 : b[30:23];
        ma = {a[30:23] != 8'h0, a[22:0]};
        mb = {b[30:23] != 8'h0, b[22:0]};
        p  = 48'(ma) * 48'(mb);
        lz    = 0;
        found = 1'b0;
        for (int i = 47; i >= 0; i--) begin
            if (!found && p[i]) begin
                lz    = 47 - i;
                found = 1'b1;
            end
        end
        pn = p << lz;
        be = int'(ea) + int'(eb) - 126 - lz;
        if (be >= 255) begin
            mag = {8'hFF, 23'h0};
        end else begin
            // Results below the normal range are denormalised before rounding.
            sh = (be >= 1) ? 0 : (1 - be);
            if (sh > 48)
                sh = 48;
            ext  = {pn, 24'h0} >> sh;
            mant = ext[71:48];
            g    = ext[47];
            st   = |ext[46:0];
            rnd  = g & (st | mant[0]);
            // Rounding carry ripples into the exponent (and into inf on overflow).
            mag  = {((be >= 1) ? 8'(be) : 8'h0), mant[22:0]} + 31'(rnd);
        end
        return {s, mag};
    endfunction

    function automatic logic [31:0] act_lane(input logic [31:0] x, input logic [1:0] mode,
                                             input logic [31:0] alpha, input logic [31:0] clip);
        logic [31:0] r, cl;
        if ((x[30:23] == 8'hFF) && (x[22:0] != 23'h0))
            return x;
        cl = clip[31] ? 32'h0 : clip;
        case (mode)
            MODE_RELU:  r = x[31] ? 32'h0 : x;
            MODE_LEAKY: r = x[31] ? fp_mul(x, alpha) : x;
            MODE_CLAMP: begin
                r = x[31] ? 32'h0 : x;
                // Both operands are non-negative here, so bit order equals value order.
                if (r[30:0] > cl[30:0])
                    r = cl;
            end
            default:    r = x;
        endcase
        return r;
    endfunction

    logic [1:0]               mode_q;
    logic [DW-1:0]            alpha_q, clip_q;
    logic [LAT-1:0]           st_v, st_l, load;
    logic [LANES-1:0][DW-1:0] st_d [LAT];
    logic [LANES-1:0][DW-1:0] act_res;

    always_comb begin
        for (int l = 0; l < LANES; l++)
            act_res[l] = act_lane(data_i[l], mode_q, alpha_q, clip_q);
    end

    // Stage k advances if any stage from k to the output has a hole, or the output drains.
    always_comb begin
        for (int k = 0; k < LAT; k++) begin
            load[k] = ready_i;
            for (int j = k; j < LAT; j++)
                if (!st_v[j])
                    load[k] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_v <= '0;
            st_l <= '0;
            for (int k = 0; k < LAT; k++)
                st_d[k] <= '0;
        end else begin
            if (load[0]) begin
                st_v[0] <= valid_i;
                st_l[0] <= last_i;
                st_d[0] <= act_res;
            end
            for (int k = 1; k < LAT; k++) begin
                if (load[k]) begin
                    st_v[k] <= st_v[k-1];
                    st_l[k] <= st_l[k-1];
                    st_d[k] <= st_d[k-1];
                end
            end
        end
    end

    assign ready_o   = load[0];
    assign cfg_rdy_o = ~|st_v && !valid_i;
    assign valid_o   = st_v[LAT-1];
    assign last_o    = st_l[LAT-1];
    assign data_o    = st_d[LAT-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mode_q  <= MODE_BYPASS;
            alpha_q <= '0;
            clip_q  <= '0;
        end else if (cfg_we_i && cfg_rdy_o) begin
            mode_q  <= cfg_mode_i;
            alpha_q <= cfg_alpha_i;
            clip_q  <= cfg_clip_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            beat_cnt_o <= 16'h0;
        else if (valid_o && ready_i) begin
            if (last_o)
                beat_cnt_o <= 16'h0;
            else if (beat_cnt_o != 16'hFFFF)
                beat_cnt_o <= beat_cnt_o + 16'h1;
        end
    end

endmodule

// File: tb/tb_act_pipe_unit.sv
// tb/tb_act_pipe_unit.sv - scoreboard bench for act_pipe_unit
module tb_act_pipe_unit;
    localparam int DW = 32;
    localparam int LANES = 4;
    localparam int LAT = 2;
    localparam int VW = DW * LANES;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rstn, cfg_we_i, cfg_rdy_o, last_i, valid_i, ready_o;
    logic                     last_o, valid_o, ready_i;
    logic [1:0]               cfg_mode_i;
    logic [DW-1:0]            cfg_alpha_i, cfg_clip_i;
    logic [LANES-1:0][DW-1:0] data_i, data_o;
    logic [15:0]              beat_cnt_o;

    act_pipe_unit #(.DW(DW), .LANES(LANES), .LAT(LAT)) dut (
        .clk(clk), .rstn(rstn),
        .cfg_we_i(cfg_we_i), .cfg_mode_i(cfg_mode_i), .cfg_alpha_i(cfg_alpha_i),
        .cfg_clip_i(cfg_clip_i), .cfg_rdy_o(cfg_rdy_o),
        .data_i(data_i), .last_i(last_i), .valid_i(valid_i), .ready_o(ready_o),
        .data_o(data_o), .last_o(last_o), .valid_o(valid_o), .ready_i(ready_i),
        .beat_cnt_o(beat_cnt_o)
    );

    typedef struct {
        logic [VW-1:0] data;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;
    int            out_cnt = 0;
    int            last_cnt = -1;
    bit            check_lat = 0;
    bit            rand_ready = 0;
    bit            in_acc, cfg_acc, prev_stall;
    logic [VW-1:0] pend_data, prev_data;
    logic          pend_last, prev_last;
    logic [15:0]   exp_cnt = 16'h0;

    task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] rep(input logic [31:0] x);
        return {LANES{x}};
    endfunction

    // One clock: observe at negedge, advance at posedge, drive at posedge+1.
    task automatic step();
        exp_t e;
        @(negedge clk);
        in_acc  = valid_i && ready_o;
        cfg_acc = cfg_we_i && cfg_rdy_o;
        check("beat_cnt", VW'(beat_cnt_o), VW'(exp_cnt));
        if (prev_stall) begin
            check("stall_valid", VW'(valid_o), VW'(1));
            check("stall_data", data_o, prev_data);
            check("stall_last", VW'(last_o), VW'(prev_last));
        end
        if (valid_o && ready_i) begin
            if (sb.size() == 0) begin
                check("unexpected_out", VW'(valid_o), VW'(0));
            end else begin
                e = sb.pop_front();
                check("data", data_o, e.data);
                check("last", VW'(last_o), VW'(e.last));
                if (check_lat)
                    check("latency", VW'(cyc + 1 - e.cyc), VW'(LAT));
                if (e.last)
                    last_cnt = int'(beat_cnt_o);
                out_cnt++;
                if (e.last)
                    exp_cnt = 16'h0;
                else if (exp_cnt != 16'hFFFF)
                    exp_cnt = exp_cnt + 16'h1;
            end
        end
        if (in_acc)
            sb.push_back('{pend_data, pend_last, cyc + 1});
        prev_stall = valid_o && !ready_i;
        prev_data  = data_o;
        prev_last  = last_o;
        @(posedge clk);
        cyc++;
        #1;
        if (rand_ready)
            ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [VW-1:0] x, input logic last, input logic [VW-1:0] exp,
                        output int n);
        pend_data = exp;
        pend_last = last;
        data_i    = x;
        last_i    = last;
        valid_i   = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!in_acc && n < 200);
        if (!in_acc)
            check("accept_timeout", VW'(in_acc), VW'(1));
    endtask

    task automatic idle();
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            step();
            n++;
        end
        check("drain", VW'(sb.size()), VW'(0));
    endtask

    task automatic cfg(input logic [1:0] mode, input logic [31:0] alpha, input logic [31:0] clip);
        int n = 0;
        cfg_mode_i  = mode;
        cfg_alpha_i = alpha;
        cfg_clip_i  = clip;
        cfg_we_i    = 1'b1;
        do begin
            step();
            n++;
        end while (!cfg_acc && n < 50);
        check("cfg_accept", VW'(cfg_acc), VW'(1));
        cfg_we_i = 1'b0;
    endtask

    initial begin
        int            n;
        logic [31:0]   xv;
        logic [VW-1:0] xs, es;
        logic [31:0]   t1_in  [4] = '{32'hC000_0000, 32'h4060_0000, 32'h8000_0000, 32'h7FC0_0001};
        logic [31:0]   t1_exp [4] = '{32'h0000_0000, 32'h4060_0000, 32'h0000_0000, 32'h7FC0_0001};
        logic [31:0]   t2_in  [5] = '{32'hC100_0000, 32'h4080_0000, 32'hBFC0_0000, 32'hFFC0_0001, 32'h8000_0000};
        logic [31:0]   t2_exp [5] = '{32'hBF80_0000, 32'h4080_0000, 32'hBE40_0000, 32'hFFC0_0001, 32'h8000_0000};
        logic [31:0]   t3_in  [5] = '{32'h40F0_0000, 32'h7F80_0000, 32'hBF80_0000, 32'h40A0_0000, 32'h40C0_0000};
        logic [31:0]   t3_exp [5] = '{32'h40C0_0000, 32'h40C0_0000, 32'h0000_0000, 32'h40A0_0000, 32'h40C0_0000};

        rstn = 1'b0; cfg_we_i = 1'b0; cfg_mode_i = 2'd0; cfg_alpha_i = '0; cfg_clip_i = '0;
        data_i = '0; last_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        pend_data = '0; pend_last = 1'b0; prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0;
        #2;
        check("rst_valid", VW'(valid_o), VW'(0));
        check("rst_last", VW'(last_o), VW'(0));
        check("rst_data", data_o, VW'(0));
        check("rst_cnt", VW'(beat_cnt_o), VW'(0));
        check("rst_cfg_rdy", VW'(cfg_rdy_o), VW'(1));
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;

        // Default mode after reset is bypass.
        send(rep(32'hC000_0000), 1'b1, rep(32'hC000_0000), n);
        idle();
        drain(10);

        // T1: relu, back-to-back, fixed latency, no bubbles.
        cfg(2'd1, 32'h0, 32'h0);
        check_lat = 1;
        for (int i = 0; i < 4; i++) begin
            send(rep(t1_in[i]), i == 3, rep(t1_exp[i]), n);
            check("t1_no_bubble", VW'(n), VW'(1));
        end
        idle();
        drain(10);
        check_lat = 0;

        // T2: leaky relu, including a round-half-to-even carry.
        cfg(2'd2, 32'h3E00_0000, 32'h0);
        for (int i = 0; i < 5; i++)
            send(rep(t2_in[i]), i == 4, rep(t2_exp[i]), n);
        idle();
        drain(10);
        cfg(2'd2, 32'h3F80_0001, 32'h0);
        send(rep(32'hBF80_0001), 1'b0, rep(32'hBF80_0002), n);
        send(rep(32'hBFC0_0000), 1'b1, rep(32'hBFC0_0002), n);
        idle();
        drain(10);

        // T3: clamp at 6.0.
        cfg(2'd3, 32'h0, 32'h40C0_0000);
        for (int i = 0; i < 5; i++)
            send(rep(t3_in[i]), i == 4, rep(t3_exp[i]), n);
        idle();
        drain(10);

        // T4: 20-beat relu frame with random backpressure.
        cfg(2'd1, 32'h0, 32'h0);
        out_cnt    = 0;
        last_cnt   = -1;
        rand_ready = 1;
        for (int i = 1; i <= 20; i++) begin
            for (int l = 0; l < LANES; l++) begin
                xv = $urandom;
                if (xv[30:23] == 8'hFF)
                    xv[23] = 1'b0;
                xs[l*DW +: DW] = xv;
                es[l*DW +: DW] = xv[31] ? 32'h0 : xv;
            end
            send(xs, i == 20, es, n);
        end
        idle();
        drain(400);
        rand_ready = 0;
        ready_i    = 1'b1;
        check("t4_count", VW'(out_cnt), VW'(20));
        check("t4_cnt_before_last", VW'(last_cnt), VW'(19));
        check("t4_cnt_after", VW'(beat_cnt_o), VW'(0));

        // T5: config write while beats are queued.
        ready_i = 1'b0;
        send(rep(32'hC000_0000), 1'b0, rep(32'h0), n);
        send(rep(32'hBF80_0000), 1'b1, rep(32'h0), n);
        idle();
        cfg_mode_i  = 2'd0;
        cfg_alpha_i = '0;
        cfg_clip_i  = '0;
        cfg_we_i    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_cfg_busy", VW'(cfg_acc), VW'(0));
        end
        ready_i = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!cfg_acc && n < 20);
        check("t5_cfg_accept", VW'(cfg_acc), VW'(1));
        cfg_we_i = 1'b0;
        check("t5_old_beats_done", VW'(sb.size()), VW'(0));
        send(rep(32'hC000_0000), 1'b1, rep(32'hC000_0000), n);
        idle();
        drain(10);

        // T6: async reset with beats in flight under backpressure.
        cfg(2'd1, 32'h0, 32'h0);
        ready_i = 1'b0;
        send(rep(32'hBF80_0000), 1'b0, rep(32'h0), n);
        send(rep(32'hBF80_0000), 1'b1, rep(32'h0), n);
        idle();
        step();
        check("t6_valid_before", VW'(valid_o), VW'(1));
        #2;
        rstn = 1'b0;
        #1;
        check("t6_valid_async", VW'(valid_o), VW'(0));
        check("t6_data_async", data_o, VW'(0));
        sb.delete();
        exp_cnt    = 16'h0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        rstn    = 1'b1;
        repeat (5) step();
        send(rep(32'hC000_0000), 1'b1, rep(32'hC000_0000), n);
        idle();
        drain(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
